// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg
//   Shared definitions for the word-serial carry-lookahead adder sequencer:
//   the controller state type, default slice geometry, and the width helper
//   for the slice index register.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int unsigned SLICE_W_DEF = 8;
  localparam int unsigned WORDS_DEF   = 4;

  // Width of the slice index; held at one bit minimum so a degenerate
  // configuration still elaborates.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// cla_slice
//   Purely combinational SLICE_W-bit carry-lookahead adder slice.
//   Every internal carry is expanded into its flattened sum-of-products
//   form over generate/propagate terms rather than rippled.
// Ports:
//   a, b  : slice operands
//   cin   : carry into bit 0
//   sum   : slice sum
//   cout  : carry out of the top bit
module cla_slice #(
  parameter int unsigned SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // c[i+1] = G[i] | P[i]G[i-1] | ... | P[i..1]G[0] | P[i..0]cin
  always_comb begin
    logic term;
    logic acc;
    term = 1'b0;
    acc  = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      acc = 1'b0;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        acc = acc | term;
      end
      term = cin;
      for (int unsigned k = 0; k <= i; k++) begin
        term = term & p[k];
      end
      c[i+1] = acc | term;
    end
  end

  assign sum  = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];

endmodule

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer
//   Adds two WORDS*SLICE_W-bit operands by streaming them, one SLICE_W-bit
//   slice per clock, through a single carry-lookahead slice, holding the
//   carry in a register between slices. Valid/ready on both sides.
//   Optional feature macro: CLA_SEQ_SUB_EN adds the in_sub port; when set at
//   accept, B is stored inverted and the carry seeded with 1 (A-B, cout=1
//   meaning no borrow).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_cin  : operands and carry-in
//   in_sub              : subtract request (CLA_SEQ_SUB_EN only)
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   out_sum, out_cout   : result and unsigned carry out
//   busy                : high in RUN or DONE
module cla_word_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned SLICE_W = SLICE_W_DEF,
  parameter int unsigned WORDS   = WORDS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORDS*SLICE_W-1:0]   in_a,
  input  logic [WORDS*SLICE_W-1:0]   in_b,
  input  logic                       in_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                       in_sub,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORDS*SLICE_W-1:0]   out_sum,
  output logic                       out_cout,
  output logic                       busy
);

  localparam int unsigned W     = WORDS * SLICE_W;
  localparam int unsigned IDX_W = idx_width(WORDS);

  seq_state_t         state;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [W-1:0]       b_load;
  logic               cin_load;
  int unsigned        base;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  // Operand conditioning applied at capture time.
  always_comb begin
`ifdef CLA_SEQ_SUB_EN
    b_load   = in_sub ? ~in_b : in_b;
    cin_load = in_sub | in_cin;
`else
    b_load   = in_b;
    cin_load = in_cin;
`endif
  end

  always_comb begin
    base    = 32'(idx_q) * SLICE_W;
    slice_a = a_q[base +: SLICE_W];
    slice_b = b_q[base +: SLICE_W];
  end

  cla_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Handshake flags are registered alongside the state so they are pure
  // state decodes with no path from in_valid or out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= b_load;
            carry_q    <= cin_load;
            idx_q      <= '0;
            sum_q      <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q[base +: SLICE_W] <= slice_sum;
          carry_q                <= slice_cout;
          if (idx_q == IDX_W'(WORDS - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb_cla_word_sequencer
//   Self-checking bench for cla_word_sequencer with SLICE_W=8, WORDS=4.
//   Expected results come from plain wide arithmetic on the operands.
//   Define CLA_SEQ_SUB_EN for both bench and RTL to cover subtraction.
module tb_cla_word_sequencer;

  localparam int unsigned SW  = 8;
  localparam int unsigned NW  = 4;
  localparam int unsigned W   = SW * NW;
  localparam int unsigned LAT = NW;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef CLA_SEQ_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  cla_word_sequencer #(
    .SLICE_W (SW),
    .WORDS   (NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CLA_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, sum} of the requested operation.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W:0] r;
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end
    return r;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    in_a   = a;
    in_b   = b;
    in_cin = cin;
`ifdef CLA_SEQ_SUB_EN
    in_sub = sub;
`else
    if (sub) $display("note: subtract step skipped in this build");
`endif
  endtask

  // Called at a negedge with the sequencer idle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input int unsigned hold);
    logic [W:0]  exp;
    int unsigned lat;
    exp = model(a, b, cin, sub);
    check({tag, ".in_ready_idle"}, {{W{1'b0}}, in_ready}, 1);
    drive(a, b, cin, sub);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    drive($urandom, $urandom, 1'($urandom), 1'b0);
    check({tag, ".busy_run"}, {{W{1'b0}}, busy, in_ready}, 2);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, (W+1)'(lat), (W+1)'(LAT));
    check({tag, ".result"}, {out_cout, out_sum}, exp);
    for (int unsigned i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      drive($urandom, $urandom, 1'($urandom), 1'b0);
      @(posedge clk);
      @(negedge clk);
      check({tag, ".hold_result"}, {out_cout, out_sum}, exp);
      check({tag, ".hold_flags"}, {{W{1'b0}}, out_valid, in_ready}, 2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".handoff"}, {{W{1'b0}}, out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   q[$];
    logic [W:0]   e;
    int           cyc;
    int           last;
    int unsigned  issued;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_flags", {{W{1'b0}}, in_ready, out_valid, busy}, 3'b100);
    check("reset_result", {out_cout, out_sum}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("carry_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    check("carry_wrap.spec", model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0), 33'h1_0000_0000);
    run_op("cin_add", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0);
    run_op("stall10", 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, 10);

    // Abort in RUN once two slices have been processed (idx=2).
    drive(32'hAAAA_5555, 32'h5555_AAAA, 1'b1, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("abort_flags", {{W{1'b0}}, in_ready, out_valid, busy}, 3'b100);
    check("abort_result", {out_cout, out_sum}, '0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_quiet", {{W{1'b0}}, out_valid, busy}, 0);
    end
    run_op("after_abort", 32'h1, 32'h1, 1'b0, 1'b0, 0);

`ifdef CLA_SEQ_SUB_EN
    run_op("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 0);
    run_op("sub_noborrow", 32'd7, 32'd5, 1'b1, 1'b1, 1);
    for (int i = 0; i < 4; i++) begin
      run_op("sub_rand", $urandom, $urandom, 1'($urandom), 1'b1, 0);
    end
`endif

    for (int i = 0; i < 6; i++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom), 1'b0, $urandom_range(0, 2));
    end

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    cyc       = 0;
    last      = -1;
    issued    = 0;
    while ((issued < 5 || q.size() > 0) && cyc < 200) begin
      if (out_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          check("b2b_result", {out_cout, out_sum}, e);
        end else begin
          check("b2b_spurious", {{W{1'b0}}, out_valid}, 0);
        end
      end
      if (in_ready) begin
        if (issued < 5) begin
          ra = $urandom;
          rb = $urandom;
          rc = 1'($urandom);
          drive(ra, rb, rc, 1'b0);
          in_valid = 1'b1;
          q.push_back(model(ra, rb, rc, 1'b0));
          if (last >= 0) check("b2b_spacing", (W+1)'(cyc - last), (W+1)'(LAT + 2));
          last = cyc;
          issued++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_timeout", (W+1)'(cyc < 200), 1);
    check("b2b_drained", (W+1)'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
